// File: rtl/bicubic_pkg.sv
// -----------------------------------------------------------------------------
// bicubic_pkg
// Shared definitions for the bicubic dot-product datapath.
//   - sign-magnitude field width helper
//   - accumulator width computation (acc_width)
//   - sm_to_tc / tc_to_sm conversions on a fixed 64-bit carrier; callers
//     narrow or widen with size casts at their own widths.
// -----------------------------------------------------------------------------
package bicubic_pkg;

    // Carrier width for the conversion helpers; every datapath width fits in it.
    localparam int SM_MAX_W = 64;

    typedef struct packed {
        logic                sign;
        logic [SM_MAX_W-1:0] mag;
    } sm_t;

    // Total bits of a sign-magnitude field holding mag_w magnitude bits.
    function automatic int sm_field_w(input int mag_w);
        return mag_w + 1;
    endfunction

    // Accumulator width: the sum of taps terms, each below 2^(w+p), stays below
    // 2^(w+p+clog2(taps)), so one extra sign bit rules out overflow.
    function automatic int acc_width(input int w_width, input int p_width, input int taps);
        return w_width + p_width + $clog2(taps) + 1;
    endfunction

    // Sign-magnitude to two's complement. Zero magnitude is always +0.
    function automatic logic signed [SM_MAX_W-1:0] sm_to_tc(input logic sign,
                                                             input logic [SM_MAX_W-1:0] mag);
        if (mag == '0) begin
            return '0;
        end
        return sign ? -$signed(mag) : $signed(mag);
    endfunction

    // Two's complement to sign-magnitude. Zero comes out with sign = 0.
    function automatic sm_t tc_to_sm(input logic signed [SM_MAX_W-1:0] v);
        sm_t r;
        r.sign = v[SM_MAX_W-1];
        r.mag  = v[SM_MAX_W-1] ? SM_MAX_W'(-v) : SM_MAX_W'(v);
        return r;
    endfunction

endpackage

// File: rtl/bicubic_sm_mult.sv
// -----------------------------------------------------------------------------
// bicubic_sm_mult
// One tap of the dot product: sign-magnitude multiply, right shift of the
// product magnitude (truncation toward zero), conversion to two's complement.
// Purely combinational; the parent registers the result.
//
// Ports:
//   w_i    [W_WIDTH:0]   weight, MSB = sign, rest = magnitude
//   p_i    [P_WIDTH:0]   pixel,  MSB = sign, rest = magnitude
//   term_o [ACC_W-1:0]   signed product term at accumulator width
// -----------------------------------------------------------------------------
module bicubic_sm_mult
    import bicubic_pkg::*;
#(
    parameter int W_WIDTH    = 3,
    parameter int P_WIDTH    = 8,
    parameter int PROD_SHIFT = 0,
    parameter int ACC_W      = 13
) (
    input  logic [W_WIDTH:0]        w_i,
    input  logic [P_WIDTH:0]        p_i,
    output logic signed [ACC_W-1:0] term_o
);

    localparam int M_W = W_WIDTH + P_WIDTH;

    logic [M_W-1:0] prod_mag;
    logic           prod_sign;

    always_comb begin
        // Shifting the magnitude, not the signed value, truncates toward zero.
        prod_mag  = (M_W'(w_i[W_WIDTH-1:0]) * M_W'(p_i[P_WIDTH-1:0])) >> PROD_SHIFT;
        prod_sign = w_i[W_WIDTH] ^ p_i[P_WIDTH];
        term_o    = ACC_W'(sm_to_tc(prod_sign, SM_MAX_W'(prod_mag)));
    end

endmodule

// File: rtl/bicubic_dot_pipe.sv
// -----------------------------------------------------------------------------
// bicubic_dot_pipe
// Pipelined sign-magnitude dot product for the bicubic interpolation path.
// Three register stages: per-tap multiply, signed sum, saturate/format.
// All stages advance on one global enable en = ~out_valid | out_ready, so a
// stalled output freezes the whole pipe and in_ready equals en.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   weights               TAPS x (W_WIDTH+1) sign-magnitude weights
//   pixels                TAPS x (P_WIDTH+1) sign-magnitude pixels
//   out_valid / out_ready output handshake
//   out_mag, out_sign     result in sign-magnitude (never negative zero)
//   out_sat               result magnitude was clipped to all ones
//   ovf_cnt [15:0]        saturated output transfers, sticky at 16'hFFFF
//                         (present only with BICUBIC_DOT_OVF_CNT_EN defined)
//
// Build option: BICUBIC_DOT_OVF_CNT_EN enables the ovf_cnt port and counter.
// -----------------------------------------------------------------------------
module bicubic_dot_pipe
    import bicubic_pkg::*;
#(
    parameter int TAPS       = 4,
    parameter int W_WIDTH    = 3,
    parameter int P_WIDTH    = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int PROD_SHIFT = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [TAPS*(W_WIDTH+1)-1:0]       weights,
    input  logic [TAPS*(P_WIDTH+1)-1:0]       pixels,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_WIDTH-1:0]              out_mag,
    output logic                              out_sign,
    output logic                              out_sat
`ifdef BICUBIC_DOT_OVF_CNT_EN
    ,
    output logic [15:0]                       ovf_cnt
`endif
);

    localparam int WS    = sm_field_w(W_WIDTH);
    localparam int PS    = sm_field_w(P_WIDTH);
    localparam int ACC_W = acc_width(W_WIDTH, P_WIDTH, TAPS);

    logic en;

    // Stage 1: per-tap terms
    logic signed [ACC_W-1:0] term_d [TAPS];
    logic signed [ACC_W-1:0] term_q [TAPS];
    logic                    s1_valid_q;

    // Stage 2: sum
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    logic                    s2_valid_q;

    // Stage 3: formatted outputs
    sm_t                     sum_sm;
    logic [OUT_WIDTH-1:0]    out_mag_d;
    logic                    out_sign_d;
    logic                    out_sat_d;
    logic [OUT_WIDTH-1:0]    out_mag_q;
    logic                    out_sign_q;
    logic                    out_sat_q;
    logic                    out_valid_q;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        bicubic_sm_mult #(
            .W_WIDTH    (W_WIDTH),
            .P_WIDTH    (P_WIDTH),
            .PROD_SHIFT (PROD_SHIFT),
            .ACC_W      (ACC_W)
        ) u_mult (
            .w_i    (weights[g*WS +: WS]),
            .p_i    (pixels[g*PS +: PS]),
            .term_o (term_d[g])
        );
    end

    // Data registers load with en regardless of valid; only the valid bits
    // decide whether anything downstream is meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                term_q[i] <= '0;
            end
        end else if (en) begin
            s1_valid_q <= in_valid;
            for (int i = 0; i < TAPS; i++) begin
                term_q[i] <= term_d[i];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + term_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            sum_q      <= sum_d;
        end
    end

    // A zero sum has sign bit 0, so negative zero cannot appear here.
    always_comb begin
        sum_sm     = tc_to_sm(SM_MAX_W'(sum_q));
        out_sat_d  = (sum_sm.mag >> OUT_WIDTH) != '0;
        out_mag_d  = out_sat_d ? '1 : OUT_WIDTH'(sum_sm.mag);
        out_sign_d = sum_sm.sign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_sign_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            out_mag_q   <= out_mag_d;
            out_sign_q  <= out_sign_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_sign  = out_sign_q;
    assign out_sat   = out_sat_q;

`ifdef BICUBIC_DOT_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_sat_q && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: doc/bicubic_dot_pipe.md
Name: bicubic_dot_pipe

Overview:
Parametrised, pipelined sign-magnitude dot product for the bicubic interpolation datapath. It generalises the fixed 4-tap combinational inner product: TAPS, operand widths and product scaling are parameters. It adds a 3-stage register pipeline with a valid/ready handshake and full-width accumulation with explicit saturation. It sits between the coefficient/window fetch and the output pixel formatter, one instance per row/column pass.

Parameters:
TAPS, 4, number of weight/pixel pairs (≥2, power of two not required)
W_WIDTH, 3, weight magnitude width (sign bit extra)
P_WIDTH, 8, pixel magnitude width (sign bit extra)
OUT_WIDTH, 8, output magnitude width
PROD_SHIFT, 0, right shift applied to each product magnitude (truncation toward zero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operands valid
in_ready  out  1  block accepts operands this cycle
weights  in  TAPS*(W_WIDTH+1)  tap i at [i*(W_WIDTH+1) +: W_WIDTH+1], MSB = sign, rest = magnitude
pixels  in  TAPS*(P_WIDTH+1)  tap i at [i*(P_WIDTH+1) +: P_WIDTH+1], MSB = sign, rest = magnitude
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_mag  out  OUT_WIDTH  result magnitude
out_sign  out  1  result sign (1 = negative)
out_sat  out  1  result was saturated (qualified by out_valid)

Behaviour:
- Reset (async assert, sync release by system): all stage valids 0; out_valid=0, out_mag=0, out_sign=0, out_sat=0. Reset mid-operation discards all in-flight data.
- Handshake: single global advance enable en = ~out_valid | out_ready. in_ready = en. Transfer in on in_valid & in_ready; out on out_valid & out_ready. While out_valid & ~out_ready, all stages hold and out_* are stable.
- Latency: 3 cycles from accepted input to out_valid. Throughput: 1 result/cycle when out_ready is held high.
- Stage 1 (multiply): per tap, mag_i = (|w_i|*|p_i|) >> PROD_SHIFT, width W_WIDTH+P_WIDTH; sign_i = w_sign ^ p_sign. Convert to two's complement of width ACC_W = W_WIDTH+P_WIDTH+clog2(TAPS)+1. A zero magnitude maps to 0 regardless of sign. Register.
- Stage 2 (sum): signed sum of all TAPS terms at ACC_W. ACC_W is wide enough that internal overflow cannot occur. Register.
- Stage 3 (format): sign = sum<0; mag = |sum|. If mag > 2^OUT_WIDTH-1: out_mag = all ones, out_sat = 1, sign kept. Else out_mag = mag, out_sat = 0. A zero sum always gives out_sign = 0 (no negative zero). Register to outputs.
- A stage valid bit advances only with en. Data regs may load regardless of valid, but outputs are only meaningful with out_valid.
- in_valid=0 with en=1 inserts a bubble; the downstream valid drops accordingly.

Optional Feature:
Macro BICUBIC_DOT_OVF_CNT_EN.
- Defined: extra output port ovf_cnt [15:0]. It increments on every output transfer with out_sat=1, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent. Datapath behaviour is identical.

Decomposition:
- Shared package bicubic_pkg: sign-magnitude field widths, ACC_W computation function (clog2), and helper functions sm_to_tc and tc_to_sm.
- Sub-module bicubic_sm_mult: one signed-magnitude multiply + shift + two's-complement conversion per tap, instantiated TAPS times in a generate loop.

Test Plan:
1. w=(+1,0,0,0), p=(+100,0,0,0), out_ready=1 -> 3 cycles later out_mag=100, out_sign=0, out_sat=0.
2. w=(-3,+6,+4,-1), all p=+10 -> out_mag=60, out_sign=0. Then w=(-2,0,0,0), p=(+50,..) -> out_mag=100, out_sign=1.
3. Cancellation and sign: w=(+1,-1,0,0), p=(+9,+9,0,0) -> out_mag=0, out_sign=0. Also w=(-3,0,0,0), p=(-5,..) -> out_mag=15, out_sign=0.
4. Saturation: all w=+7, all p=+255 -> out_mag=255, out_sat=1, out_sign=0. All w=-7 -> out_mag=255, out_sign=1. With the macro defined, ovf_cnt=2.
5. Backpressure: 5 back-to-back inputs, out_ready=0 from cycle 0 -> 3 accepted, in_ready=0 from cycle 3, out_* stable. Raise out_ready -> 5 results in order, none lost or duplicated.
6. Reset mid-stream: assert rst_n=0 with 2 items in flight -> out_valid=0 immediately. After release, the first new input appears after exactly 3 cycles.
